// File: rtl/apb_regfile_completer.sv
// APB4 completer holding a bank of 32-bit registers with byte-strobe writes,
// a fixed number of access-phase wait states and slave-error signalling.
// Register 0 is a read-only identification word.
module apb_regfile_completer #(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 0,
   parameter int          PRIV_START  = 8,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic                     psel,
   input  logic                     penable,
   input  logic [31:0]              paddr,
   input  logic                     pwrite,
   input  logic [2:0]               pprot,
   input  logic [31:0]              pwdata,
   input  logic [3:0]               pstrb,
   output logic [31:0]              prdata,
   output logic                     pready,
   output logic                     pslverr,
   output logic [NUM_REGS*32-1:0]   regs_out
);

   localparam int AW = $clog2(NUM_REGS);
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state;
   logic [31:0]   regs [NUM_REGS];
   logic [3:0]    count;
   logic [AW-1:0] cap_idx;
   logic          cap_write;
   logic          cap_err;
   logic [31:0]   cap_wdata;
   logic [31:0]   cap_resp;
   logic [3:0]    cap_strb;

   logic [AW-1:0] idx;
   logic          setup_err;
   logic [31:0]   read_val;
   logic [31:0]   setup_resp;
   logic          setup_hit;
   logic          commit;
   logic          unused_prot;

   assign idx         = paddr[AW+1:2];
   assign setup_hit   = psel && !penable;
   assign unused_prot = &{1'b0, pprot[2:1]};

   // Decode the address and access type presented in the setup phase into an error flag and the response word
   always_comb begin
      setup_err = 1'b0;
      if (paddr[1:0] != 2'b00)                                         setup_err = 1'b1;
      if ((paddr >> (AW + 2)) != 32'd0)                                setup_err = 1'b1;
      if (pwrite && (idx == '0))                                       setup_err = 1'b1;
      if (pwrite && !pprot[0] && (32'(idx) >= 32'(PRIV_START)))        setup_err = 1'b1;
      if (!pwrite && (pstrb != 4'b0000))                               setup_err = 1'b1;
      read_val   = (idx == '0) ? ID_VALUE : regs[idx];
      setup_resp = (setup_err || pwrite) ? 32'd0 : read_val;
   end

   assign commit = (state == ACCESS) && pready && psel && penable && cap_write && !cap_err;

   // Transfer sequencer: capture in setup, count wait states, respond, then retire or abort
   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         prdata    <= 32'd0;
         count     <= 4'd0;
         cap_idx   <= '0;
         cap_write <= 1'b0;
         cap_err   <= 1'b0;
         cap_wdata <= 32'd0;
         cap_resp  <= 32'd0;
         cap_strb  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               prdata  <= 32'd0;
               if (setup_hit) begin
                  cap_idx   <= idx;
                  cap_write <= pwrite;
                  cap_err   <= setup_err;
                  cap_wdata <= pwdata;
                  cap_resp  <= setup_resp;
                  cap_strb  <= pstrb;
                  count     <= 4'd0;
                  state     <= ACCESS;
                  if (WAIT_CYCLES == 0) begin
                     pready  <= 1'b1;
                     pslverr <= setup_err;
                     prdata  <= setup_resp;
                  end
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state   <= IDLE;
                  pready  <= 1'b0;
                  pslverr <= 1'b0;
                  prdata  <= 32'd0;
               end else if (!pready) begin
                  count <= count + 4'd1;
                  if ((count + 4'd1) == WAIT_LAST) begin
                     pready  <= 1'b1;
                     pslverr <= cap_err;
                     prdata  <= cap_resp;
                  end
               end else if (penable) begin
                  state   <= IDLE;
                  pready  <= 1'b0;
                  pslverr <= 1'b0;
                  prdata  <= 32'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register bank: cleared on reset, byte lanes written when a good write completes
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
      end else if (commit) begin
         for (int k = 0; k < 4; k++) begin
            if (cap_strb[k]) regs[cap_idx][8*k +: 8] <= cap_wdata[8*k +: 8];
         end
      end
   end

   // Flat export of the bank, one cycle behind the bank itself, with slot 0 showing the ID word
   always_ff @(posedge pclk) begin
      if (preset) begin
         regs_out <= '0;
         regs_out[31:0] <= ID_VALUE;
      end else begin
         regs_out[31:0] <= ID_VALUE;
         for (int i = 1; i < NUM_REGS; i++) regs_out[32*i +: 32] <= regs[i];
      end
   end

endmodule
